// File: rtl/dsp_aw_channel.sv
// Per-master AW dispatcher: decodes the target slave and tracks per-burst W routing.
// Optional WLAST consistency check enabled by defining DSP_AW_WLAST_CHK_EN.

// In-order FIFO with registered storage; head entry is visible on rd_dat.
// Latency: a pushed entry reaches the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; no full bypass.
module dsp_aw_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr  = wr_vld & ~full;
  assign do_rd  = rd_rdy & ~empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// Forwards master AW to the decoded slave and steers W beats burst by burst.
// Latency: AW appears on sa_AW* one cycle after acceptance; W routes from the next cycle.
// Backpressure: AWREADY drops when the output slot is stalled or the route FIFO is full.
module dsp_aw_channel #(
  parameter int SLV_AMT        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int TRANS_ID_W     = 5,
  parameter int LEN_W          = 8,
  parameter int OUTST_AMT      = 4,
  parameter int SLV_ID_W       = $clog2(SLV_AMT),
  parameter int SLV_ID_MSB_IDX = 30,
  parameter int SLV_ID_LSB_IDX = 30
) (
  input  logic                  ACLK_i,
  input  logic                  ARESETn_i,
  input  logic [TRANS_ID_W-1:0] m_AWID_i,
  input  logic [ADDR_WIDTH-1:0] m_AWADDR_i,
  input  logic [LEN_W-1:0]      m_AWLEN_i,
  input  logic                  m_AWVALID_i,
  output logic                  m_AWREADY_o,
  output logic [TRANS_ID_W-1:0] sa_AWID_o,
  output logic [ADDR_WIDTH-1:0] sa_AWADDR_o,
  output logic [LEN_W-1:0]      sa_AWLEN_o,
  output logic [SLV_AMT-1:0]    sa_AWVALID_o,
  input  logic [SLV_AMT-1:0]    sa_AWREADY_i,
  output logic [SLV_ID_W-1:0]   dsp_WDATA_slv_id_o,
  output logic                  dsp_WDATA_disable_o,
  input  logic                  dsp_WDATA_WVALID_i,
  input  logic                  dsp_WDATA_WREADY_i
`ifdef DSP_AW_WLAST_CHK_EN
  ,
  input  logic                  dsp_WDATA_WLAST_i,
  output logic                  err_WLAST_o
`endif
);

  typedef struct packed {
    logic [SLV_ID_W-1:0] slv_id;
    logic [LEN_W-1:0]    len;
  } route_t;

  typedef struct packed {
    logic [SLV_ID_W-1:0]   slv_id;
    logic [TRANS_ID_W-1:0] awid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_W-1:0]      len;
  } aw_slot_t;

  aw_slot_t            slot_q;
  logic                slot_vld;
  logic [SLV_ID_W-1:0] aw_slv_id;
  logic                aw_drainable;
  logic                aw_acc;

  route_t              route_push_dat;
  route_t              route_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                w_beat;
  logic                w_last;
  logic                route_pop;
  logic [LEN_W-1:0]    beat_cnt;

  assign aw_slv_id    = m_AWADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
  assign aw_drainable = ~slot_vld | sa_AWREADY_i[slot_q.slv_id];
  // Full FIFO blocks even when a pop is pending this cycle.
  assign m_AWREADY_o  = ARESETn_i & aw_drainable & ~fifo_full;
  assign aw_acc       = m_AWVALID_i & m_AWREADY_o;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      slot_vld <= 1'b0;
      slot_q   <= '0;
    end else if (aw_acc) begin
      slot_vld <= 1'b1;
      slot_q   <= '{slv_id: aw_slv_id, awid: m_AWID_i, addr: m_AWADDR_i, len: m_AWLEN_i};
    end else if (slot_vld && sa_AWREADY_i[slot_q.slv_id]) begin
      slot_vld <= 1'b0;
    end
  end

  always_comb begin
    sa_AWVALID_o = '0;
    if (slot_vld) sa_AWVALID_o[slot_q.slv_id] = 1'b1;
  end

  assign sa_AWID_o   = slot_q.awid;
  assign sa_AWADDR_o = slot_q.addr;
  assign sa_AWLEN_o  = slot_q.len;

  assign route_push_dat = '{slv_id: aw_slv_id, len: m_AWLEN_i};

  dsp_aw_fifo #(
    .W     ($bits(route_t)),
    .DEPTH (OUTST_AMT)
  ) u_route_fifo (
    .core_clk (ACLK_i),
    .arst_n   (ARESETn_i),
    .wr_vld   (aw_acc),
    .wr_dat   (route_push_dat),
    .rd_rdy   (route_pop),
    .rd_dat   (route_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign dsp_WDATA_disable_o = fifo_empty;
  assign dsp_WDATA_slv_id_o  = route_head.slv_id;

  assign w_beat    = dsp_WDATA_WVALID_i & dsp_WDATA_WREADY_i & ~fifo_empty;
  assign w_last    = (beat_cnt == route_head.len);
  assign route_pop = w_beat & w_last;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      beat_cnt <= '0;
    end else if (w_beat) begin
      beat_cnt <= w_last ? '0 : beat_cnt + LEN_W'(1);
    end
  end

`ifdef DSP_AW_WLAST_CHK_EN
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      err_WLAST_o <= 1'b0;
    end else if (w_beat && (dsp_WDATA_WLAST_i != w_last)) begin
      err_WLAST_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_aw_channel.sv
// Testbench for dsp_aw_channel: directed scenarios plus randomized traffic against a queue model.
module tb_dsp_aw_channel;

  localparam int SLV_AMT   = 2;
  localparam int OUTST_AMT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awvalid;
  logic        m_awready;
  logic [4:0]  sa_awid;
  logic [31:0] sa_awaddr;
  logic [7:0]  sa_awlen;
  logic [1:0]  sa_awvalid;
  logic [1:0]  sa_awready;
  logic        w_slv_id;
  logic        w_disable;
  logic        w_vld;
  logic        w_rdy;
`ifdef DSP_AW_WLAST_CHK_EN
  logic        w_last;
  logic        err_wlast;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_aw_channel dut (
    .ACLK_i              (clk),
    .ARESETn_i           (rst_n),
    .m_AWID_i            (m_awid),
    .m_AWADDR_i          (m_awaddr),
    .m_AWLEN_i           (m_awlen),
    .m_AWVALID_i         (m_awvalid),
    .m_AWREADY_o         (m_awready),
    .sa_AWID_o           (sa_awid),
    .sa_AWADDR_o         (sa_awaddr),
    .sa_AWLEN_o          (sa_awlen),
    .sa_AWVALID_o        (sa_awvalid),
    .sa_AWREADY_i        (sa_awready),
    .dsp_WDATA_slv_id_o  (w_slv_id),
    .dsp_WDATA_disable_o (w_disable),
    .dsp_WDATA_WVALID_i  (w_vld),
    .dsp_WDATA_WREADY_i  (w_rdy)
`ifdef DSP_AW_WLAST_CHK_EN
    ,
    .dsp_WDATA_WLAST_i   (w_last),
    .err_WLAST_o         (err_wlast)
`endif
  );

  // Reference model: outstanding bursts as a queue, beats done on the head, one pending AW slot.
  typedef struct {
    int id;
    int len;
  } route_s;

  route_s      mq[$];
  int          m_done;
  bit          m_slot_vld;
  int          m_slot_id;
  logic [31:0] m_slot_addr;
  logic [4:0]  m_slot_awid;
  logic [7:0]  m_slot_len;
  bit          m_acc;
  bit          m_beat;
  route_s      m_new;

  function automatic bit exp_awready();
    return (rst_n === 1'b1) && (!m_slot_vld || sa_awready[m_slot_id] === 1'b1) &&
           (mq.size() < OUTST_AMT);
  endfunction

  function automatic logic [1:0] exp_awvalid();
    return m_slot_vld ? 2'(1 << m_slot_id) : 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_done     = 0;
      m_slot_vld = 0;
    end else begin
      m_acc  = (m_awvalid === 1'b1) && exp_awready();
      m_beat = (w_vld === 1'b1) && (w_rdy === 1'b1) && (mq.size() > 0);
      if (m_slot_vld && sa_awready[m_slot_id] === 1'b1) m_slot_vld = 0;
      if (m_beat) begin
        m_done++;
        if (m_done > mq[0].len) begin
          void'(mq.pop_front());
          m_done = 0;
        end
      end
      if (m_acc) begin
        m_slot_vld  = 1;
        m_slot_id   = int'(m_awaddr[30]);
        m_slot_addr = m_awaddr;
        m_slot_awid = m_awid;
        m_slot_len  = m_awlen;
        m_new.id    = int'(m_awaddr[30]);
        m_new.len   = int'(m_awlen);
        mq.push_back(m_new);
      end
    end
  end

  task automatic idle_inputs();
    m_awvalid  = 1'b0;
    m_awid     = '0;
    m_awaddr   = '0;
    m_awlen    = '0;
    sa_awready = 2'b11;
    w_vld      = 1'b0;
    w_rdy      = 1'b1;
`ifdef DSP_AW_WLAST_CHK_EN
    w_last     = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    #7;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    m_awvalid  = 1'b1;
    m_awaddr   = 32'h4000_0000;
    m_awlen    = 8'd0;
    m_awid     = 5'd1;
    sa_awready = 2'b11;
    w_vld      = 1'b1;
    w_rdy      = 1'b1;
`ifdef DSP_AW_WLAST_CHK_EN
    w_last     = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #2;
    total++; if (m_awready !== 1'b0) begin bad++; $display("FAIL reset_awready: got %b want 0", m_awready); end
    total++; if (sa_awvalid !== 2'b00) begin bad++; $display("FAIL reset_awvalid: got %b want 00", sa_awvalid); end
    total++; if (w_disable !== 1'b1) begin bad++; $display("FAIL reset_disable: got %b want 1", w_disable); end
    total++; if (w_slv_id !== 1'b0) begin bad++; $display("FAIL reset_slv_id: got %b want 0", w_slv_id); end
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (m_awready !== 1'b1) begin bad++; $display("FAIL post_reset_awready: got %b want 1", m_awready); end
  endtask

  task automatic test_single();
    m_awaddr   = 32'h4000_0000;
    m_awlen    = 8'd3;
    m_awid     = 5'd7;
    m_awvalid  = 1'b1;
    sa_awready = 2'b11;
    #1;
    total++; if (m_awready !== 1'b1) begin bad++; $display("FAIL single_awready: got %b want 1", m_awready); end
    total++; if (w_disable !== 1'b1) begin bad++; $display("FAIL single_disable_same_cycle: got %b want 1", w_disable); end
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    #1;
    total++; if (sa_awvalid !== 2'b10) begin bad++; $display("FAIL single_awvalid: got %b want 10", sa_awvalid); end
    total++; if (sa_awaddr !== 32'h4000_0000 || sa_awid !== 5'd7 || sa_awlen !== 8'd3) begin
      bad++; $display("FAIL single_aw_fields: got %h/%0d/%0d want 40000000/7/3", sa_awaddr, sa_awid, sa_awlen);
    end
    total++; if (w_slv_id !== 1'b1) begin bad++; $display("FAIL single_slv_id: got %b want 1", w_slv_id); end
    w_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (w_disable !== 1'b0) begin bad++; $display("FAIL single_beat%0d_disable: got %b want 0", i, w_disable); end
      @(posedge clk); #1;
    end
    w_vld = 1'b0;
    #1;
    total++; if (w_disable !== 1'b1) begin bad++; $display("FAIL single_done_disable: got %b want 1", w_disable); end
    total++; if (sa_awvalid !== 2'b00) begin bad++; $display("FAIL single_drained: got %b want 00", sa_awvalid); end
  endtask

  task automatic test_back_to_back();
    int exp_ids[3] = '{0, 1, 1};
    sa_awready = 2'b11;
    m_awaddr   = 32'h0000_0000;
    m_awlen    = 8'd0;
    m_awid     = 5'd1;
    m_awvalid  = 1'b1;
    @(posedge clk); #1;
    m_awaddr = 32'h4000_0000;
    m_awlen  = 8'd1;
    m_awid   = 5'd2;
    #1;
    total++; if (sa_awvalid !== 2'b01 || m_awready !== 1'b1) begin
      bad++; $display("FAIL b2b_first: got awvalid=%b awready=%b want 01/1", sa_awvalid, m_awready);
    end
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    w_vld     = 1'b1;
    #1;
    total++; if (sa_awvalid !== 2'b10) begin bad++; $display("FAIL b2b_second: got %b want 10", sa_awvalid); end
    for (int i = 0; i < 3; i++) begin
      total++; if (w_disable !== 1'b0 || w_slv_id !== 1'(exp_ids[i])) begin
        bad++; $display("FAIL b2b_beat%0d: got disable=%b id=%b want 0/%0d", i, w_disable, w_slv_id, exp_ids[i]);
      end
      @(posedge clk); #1;
    end
    w_vld = 1'b0;
    #1;
    total++; if (w_disable !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", w_disable); end
  endtask

  task automatic test_stall();
    sa_awready = 2'b00;
    m_awaddr   = 32'h0000_1230;
    m_awid     = 5'd3;
    m_awlen    = 8'd2;
    m_awvalid  = 1'b1;
    @(posedge clk); #1;
    m_awaddr = 32'h4000_0040;
    m_awid   = 5'd4;
    m_awlen  = 8'd0;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (m_awready !== 1'b0 || sa_awvalid !== 2'b01 || sa_awaddr !== 32'h0000_1230 || sa_awid !== 5'd3) begin
        bad++; $display("FAIL stall_cyc%0d: got rdy=%b vld=%b addr=%h id=%0d want 0/01/00001230/3",
                        i, m_awready, sa_awvalid, sa_awaddr, sa_awid);
      end
      @(posedge clk); #1;
    end
    sa_awready = 2'b01;
    #1;
    total++; if (m_awready !== 1'b1) begin bad++; $display("FAIL stall_release_rdy: got %b want 1", m_awready); end
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    #1;
    total++; if (sa_awvalid !== 2'b10 || sa_awaddr !== 32'h4000_0040) begin
      bad++; $display("FAIL stall_second: got %b/%h want 10/40000040", sa_awvalid, sa_awaddr);
    end
    apply_reset();
  endtask

  task automatic test_full();
    int lens[4] = '{1, 0, 2, 0};
    int ids[4]  = '{0, 1, 1, 0};
    sa_awready = 2'b11;
    m_awvalid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_awaddr = (ids[i] != 0) ? 32'h4000_0000 : 32'h0000_0000;
      m_awlen  = 8'(lens[i]);
      #1;
      total++; if (m_awready !== 1'b1) begin bad++; $display("FAIL full_fill%0d: got %b want 1", i, m_awready); end
      @(posedge clk); #1;
    end
    m_awaddr = 32'h4000_0100;
    m_awlen  = 8'd0;
    #1;
    total++; if (m_awready !== 1'b0 || w_slv_id !== 1'b0) begin
      bad++; $display("FAIL full_blocked: got rdy=%b id=%b want 0/0", m_awready, w_slv_id);
    end
    @(posedge clk); #1;
    w_vld = 1'b1;
    #1;
    total++; if (m_awready !== 1'b0) begin bad++; $display("FAIL full_beat0: got %b want 0", m_awready); end
    @(posedge clk); #1;
    total++; if (m_awready !== 1'b0) begin bad++; $display("FAIL full_no_bypass: got %b want 0", m_awready); end
    @(posedge clk); #1;
    w_vld = 1'b0;
    #1;
    total++; if (m_awready !== 1'b1 || w_slv_id !== 1'b1) begin
      bad++; $display("FAIL full_after_pop: got rdy=%b id=%b want 1/1", m_awready, w_slv_id);
    end
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    #1;
    total++; if (m_awready !== 1'b0 || exp_awready() !== 1'b0) begin
      bad++; $display("FAIL full_refilled: got %b want 0", m_awready);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    sa_awready = 2'b11;
    m_awaddr   = 32'h4000_0000;
    m_awlen    = 8'd3;
    m_awvalid  = 1'b1;
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    w_vld     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    w_vld = 1'b0;
    #2;
    total++; if (w_disable !== 1'b1 || sa_awvalid !== 2'b00 || m_awready !== 1'b0) begin
      bad++; $display("FAIL midrst_state: got dis=%b vld=%b rdy=%b want 1/00/0", w_disable, sa_awvalid, m_awready);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    m_awaddr  = 32'h0000_0800;
    m_awlen   = 8'd1;
    m_awvalid = 1'b1;
    #1;
    total++; if (m_awready !== 1'b1) begin bad++; $display("FAIL midrst_fresh_rdy: got %b want 1", m_awready); end
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    w_vld     = 1'b1;
    #1;
    total++; if (sa_awvalid !== 2'b01 || w_slv_id !== 1'b0 || w_disable !== 1'b0) begin
      bad++; $display("FAIL midrst_fresh_route: got vld=%b id=%b dis=%b want 01/0/0", sa_awvalid, w_slv_id, w_disable);
    end
    @(posedge clk); #1;
    total++; if (w_disable !== 1'b0) begin bad++; $display("FAIL midrst_beat1: got %b want 0", w_disable); end
    @(posedge clk); #1;
    w_vld = 1'b0;
    #1;
    total++; if (w_disable !== 1'b1) begin bad++; $display("FAIL midrst_done: got %b want 1", w_disable); end
  endtask

  task automatic test_random();
    bit hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        m_awvalid = 1'($urandom_range(0, 1));
        m_awaddr  = $urandom();
        m_awlen   = 8'($urandom_range(0, 3));
        m_awid    = 5'($urandom_range(0, 31));
      end
      sa_awready = 2'($urandom_range(0, 3));
      w_vld      = ($urandom_range(0, 3) != 0);
      w_rdy      = ($urandom_range(0, 4) != 0);
      #1;
      total++; if (m_awready !== exp_awready()) begin
        bad++; $display("FAIL rand_awready c%0d: got %b want %b", c, m_awready, exp_awready());
      end
      total++; if (sa_awvalid !== exp_awvalid()) begin
        bad++; $display("FAIL rand_awvalid c%0d: got %b want %b", c, sa_awvalid, exp_awvalid());
      end
      total++; if (w_disable !== (mq.size() == 0)) begin
        bad++; $display("FAIL rand_disable c%0d: got %b want %b", c, w_disable, mq.size() == 0);
      end
      if (mq.size() > 0) begin
        total++; if (w_slv_id !== 1'(mq[0].id)) begin
          bad++; $display("FAIL rand_slv_id c%0d: got %b want %0d", c, w_slv_id, mq[0].id);
        end
      end
      if (m_slot_vld) begin
        total++; if (sa_awaddr !== m_slot_addr || sa_awid !== m_slot_awid || sa_awlen !== m_slot_len) begin
          bad++; $display("FAIL rand_aw_fields c%0d: got %h/%0d/%0d want %h/%0d/%0d", c,
                          sa_awaddr, sa_awid, sa_awlen, m_slot_addr, m_slot_awid, m_slot_len);
        end
      end
      hold = m_awvalid && !exp_awready();
      @(posedge clk); #1;
    end
    apply_reset();
  endtask

`ifdef DSP_AW_WLAST_CHK_EN
  task automatic test_wlast();
    sa_awready = 2'b11;
    m_awaddr   = 32'h0000_0000;
    m_awlen    = 8'd1;
    m_awvalid  = 1'b1;
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    w_vld     = 1'b1;
    w_last    = 1'b1;
    #1;
    total++; if (err_wlast !== 1'b0) begin bad++; $display("FAIL wlast_before: got %b want 0", err_wlast); end
    @(posedge clk); #1;
    total++; if (err_wlast !== 1'b1) begin bad++; $display("FAIL wlast_set: got %b want 1", err_wlast); end
    @(posedge clk); #1;
    w_vld  = 1'b0;
    w_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (err_wlast !== 1'b1) begin bad++; $display("FAIL wlast_sticky: got %b want 1", err_wlast); end
    apply_reset();
    #1;
    total++; if (err_wlast !== 1'b0) begin bad++; $display("FAIL wlast_cleared: got %b want 0", err_wlast); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_full();
    test_reset_mid();
    test_random();
`ifdef DSP_AW_WLAST_CHK_EN
    test_wlast();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
